// File: rtl/ppu_fetch_arbiter.sv
// ppu_fetch_arbiter
//   Shares the single PPU VRAM/OAM read port between the background fetcher
//   and the sprite fetcher. Ownership is granted for a whole fetch sequence
//   (lock), with the sprite fetcher winning over the background fetcher.
//   Only one read is outstanding at a time on the fixed-latency port, and each
//   response is routed back to the requester that issued it.
//
// Ports
//   clk_in, rst_in                    clock, synchronous active-high reset
//   bg_lock_in/bg_req_in/bg_addr_in   background sequence lock, request, address
//   bg_ack_out/bg_rvalid_out          background issue pulse, response pulse
//   bg_rdata_out                      background read data (0xFF when invalid)
//   bg_yield_out                      sprite is waiting; background should drop lock
//   spr_lock_in/spr_req_in/spr_addr_in sprite sequence lock, request, address
//   spr_ack_out/spr_rvalid_out        sprite issue pulse, response pulse
//   spr_rdata_out                     sprite read data (0xFF when invalid)
//   mem_free_out                      port not owned by background
//   mem_addr_out/mem_req_out          memory read address and one-cycle strobe
//   mem_data_in/mem_data_valid_in     memory read data and its valid flag
module ppu_fetch_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              bg_lock_in,
  input  logic              bg_req_in,
  input  logic [ADDR_W-1:0] bg_addr_in,
  output logic              bg_ack_out,
  output logic [7:0]        bg_rdata_out,
  output logic              bg_rvalid_out,
  output logic              bg_yield_out,
  input  logic              spr_lock_in,
  input  logic              spr_req_in,
  input  logic [ADDR_W-1:0] spr_addr_in,
  output logic              spr_ack_out,
  output logic [7:0]        spr_rdata_out,
  output logic              spr_rvalid_out,
  output logic              mem_free_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_req_out,
  input  logic [7:0]        mem_data_in,
  input  logic              mem_data_valid_in
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_BG   = 2'd1,
    OWN_SPR  = 2'd2
  } owner_e;

  owner_e              owner_q, owner_d;
  logic                inflight_q, inflight_d;
  logic                tagSpr_q, tagSpr_d;
  logic [RD_LATENCY-1:0] pipeValid_q;

  logic                issueBg, issueSpr, issue, respDone;
  logic [7:0]          respData;

  logic                bgAck_q, sprAck_q, bgRvalid_q, sprRvalid_q;
  logic [7:0]          bgRdata_q, sprRdata_q;
  logic                bgYield_q, memFree_q, memReq_q;
  logic [ADDR_W-1:0]   memAddr_q;

  // Issue decision, response detection and owner next-state.
  // An owner that is issuing in the same cycle it drops its lock is kept one
  // more cycle so the outstanding read always belongs to the current owner.
  always_comb begin
    issueBg   = (owner_q == OWN_BG)  && bg_req_in  && !inflight_q;
    issueSpr  = (owner_q == OWN_SPR) && spr_req_in && !inflight_q;
    issue     = issueBg || issueSpr;
    // The last pipeline stage marks the cycle in which memory data is sampled.
    respDone  = pipeValid_q[RD_LATENCY-1];
    respData  = mem_data_valid_in ? mem_data_in : 8'hFF;

    owner_d    = owner_q;
    inflight_d = inflight_q;
    tagSpr_d   = tagSpr_q;

    if (issue) begin
      inflight_d = 1'b1;
      tagSpr_d   = issueSpr;
    end else if (respDone) begin
      inflight_d = 1'b0;
    end

    case (owner_q)
      OWN_IDLE: begin
        if (spr_lock_in)     owner_d = OWN_SPR;
        else if (bg_lock_in) owner_d = OWN_BG;
      end
      OWN_BG: begin
        if (!bg_lock_in && !inflight_q && !issueBg) owner_d = OWN_IDLE;
      end
      OWN_SPR: begin
        if (!spr_lock_in && !inflight_q && !issueSpr) owner_d = OWN_IDLE;
      end
      default: owner_d = OWN_IDLE;
    endcase
  end

  // State, read-latency pipeline and registered outputs.
  // The pipeline is fed by the memory strobe so its last stage lines up with
  // the cycle RD_LATENCY after mem_req_out was high.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      owner_q     <= OWN_IDLE;
      inflight_q  <= 1'b0;
      tagSpr_q    <= 1'b0;
      pipeValid_q <= '0;
      bgAck_q     <= 1'b0;
      sprAck_q    <= 1'b0;
      bgRvalid_q  <= 1'b0;
      sprRvalid_q <= 1'b0;
      bgRdata_q   <= 8'h00;
      sprRdata_q  <= 8'h00;
      bgYield_q   <= 1'b0;
      memFree_q   <= 1'b1;
      memReq_q    <= 1'b0;
      memAddr_q   <= '0;
    end else begin
      owner_q    <= owner_d;
      inflight_q <= inflight_d;
      tagSpr_q   <= tagSpr_d;

      pipeValid_q[0] <= memReq_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipeValid_q[i] <= pipeValid_q[i-1];
      end

      memReq_q <= issue;
      bgAck_q  <= issueBg;
      sprAck_q <= issueSpr;
      if (issueSpr)     memAddr_q <= spr_addr_in;
      else if (issueBg) memAddr_q <= bg_addr_in;

      bgRvalid_q  <= respDone && !tagSpr_q;
      sprRvalid_q <= respDone && tagSpr_q;
      if (respDone && !tagSpr_q) bgRdata_q  <= respData;
      if (respDone && tagSpr_q)  sprRdata_q <= respData;

      memFree_q <= (owner_d != OWN_BG);
      bgYield_q <= spr_lock_in && (owner_d == OWN_BG);
    end
  end

  assign bg_ack_out     = bgAck_q;
  assign bg_rdata_out   = bgRdata_q;
  assign bg_rvalid_out  = bgRvalid_q;
  assign bg_yield_out   = bgYield_q;
  assign spr_ack_out    = sprAck_q;
  assign spr_rdata_out  = sprRdata_q;
  assign spr_rvalid_out = sprRvalid_q;
  assign mem_free_out   = memFree_q;
  assign mem_addr_out   = memAddr_q;
  assign mem_req_out    = memReq_q;

endmodule

// File: tb/tb_ppu_fetch_arbiter.sv
// tb_ppu_fetch_arbiter
//   Directed-vector bench for ppu_fetch_arbiter with RD_LATENCY=2.
//   Inputs change 1 time unit after a rising edge; outputs are inspected there
//   too, so each tick() moves exactly one clock cycle forward.
module tb_ppu_fetch_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        bg_lock_in, bg_req_in, spr_lock_in, spr_req_in;
  logic [15:0] bg_addr_in, spr_addr_in;
  logic        bg_ack_out, bg_rvalid_out, bg_yield_out;
  logic        spr_ack_out, spr_rvalid_out;
  logic [7:0]  bg_rdata_out, spr_rdata_out;
  logic        mem_free_out, mem_req_out;
  logic [15:0] mem_addr_out;
  logic [7:0]  mem_data_in;
  logic        mem_data_valid_in;

  int total = 0;
  int bad   = 0;

  ppu_fetch_arbiter #(.ADDR_W(16), .RD_LATENCY(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .bg_lock_in(bg_lock_in), .bg_req_in(bg_req_in), .bg_addr_in(bg_addr_in),
    .bg_ack_out(bg_ack_out), .bg_rdata_out(bg_rdata_out),
    .bg_rvalid_out(bg_rvalid_out), .bg_yield_out(bg_yield_out),
    .spr_lock_in(spr_lock_in), .spr_req_in(spr_req_in), .spr_addr_in(spr_addr_in),
    .spr_ack_out(spr_ack_out), .spr_rdata_out(spr_rdata_out),
    .spr_rvalid_out(spr_rvalid_out), .mem_free_out(mem_free_out),
    .mem_addr_out(mem_addr_out), .mem_req_out(mem_req_out),
    .mem_data_in(mem_data_in), .mem_data_valid_in(mem_data_valid_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Leaves the bench in cycle 0 with reset released and all inputs idle.
  task automatic do_reset();
    rst_in = 1'b1;
    bg_lock_in = 0; bg_req_in = 0; bg_addr_in = '0;
    spr_lock_in = 0; spr_req_in = 0; spr_addr_in = '0;
    mem_data_in = 8'h00; mem_data_valid_in = 1'b0;
    tick(); tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({mem_free_out, mem_req_out, bg_ack_out, spr_ack_out, bg_rvalid_out,
         spr_rvalid_out, bg_yield_out} !== 7'b1000000) begin
      bad++;
      $display("[TB] FAIL reset_strobes got=%b want=1000000",
               {mem_free_out, mem_req_out, bg_ack_out, spr_ack_out, bg_rvalid_out,
                spr_rvalid_out, bg_yield_out});
    end
    total++;
    if ({bg_rdata_out, spr_rdata_out, mem_addr_out} !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_data got=%h want=0",
               {bg_rdata_out, spr_rdata_out, mem_addr_out});
    end
  endtask

  task automatic test_bg_read();
    do_reset();
    bg_lock_in = 1; bg_req_in = 1; bg_addr_in = 16'h9800;
    tick();                                        // cycle 1: owner BG
    total++;
    if (mem_free_out !== 1'b0) begin
      bad++; $display("[TB] FAIL bg_memfree got=%b want=0", mem_free_out);
    end
    tick();                                        // cycle 2: issue
    total++;
    if ({mem_req_out, bg_ack_out, mem_addr_out} !== {1'b1, 1'b1, 16'h9800}) begin
      bad++;
      $display("[TB] FAIL bg_issue got=%b%b %h want=11 9800", mem_req_out, bg_ack_out, mem_addr_out);
    end
    bg_req_in = 0; mem_data_in = 8'h3C; mem_data_valid_in = 1;
    tick(); tick();                                // cycles 3,4
    total++;
    if (bg_rvalid_out !== 1'b0) begin
      bad++; $display("[TB] FAIL bg_early_rvalid got=%b want=0", bg_rvalid_out);
    end
    tick();                                        // cycle 5: response
    total++;
    if ({bg_rvalid_out, bg_rdata_out, spr_rvalid_out} !== {1'b1, 8'h3C, 1'b0}) begin
      bad++;
      $display("[TB] FAIL bg_resp got=%b %h %b want=1 3c 0", bg_rvalid_out, bg_rdata_out, spr_rvalid_out);
    end
    bg_lock_in = 0;
    tick();                                        // cycle 6: pulse over, owner IDLE
    total++;
    if ({bg_rvalid_out, bg_rdata_out, mem_free_out} !== {1'b0, 8'h3C, 1'b1}) begin
      bad++;
      $display("[TB] FAIL bg_release got=%b %h %b want=0 3c 1", bg_rvalid_out, bg_rdata_out, mem_free_out);
    end
  endtask

  task automatic test_priority();
    int acks;
    do_reset();
    bg_lock_in = 1; spr_lock_in = 1; bg_req_in = 1; bg_addr_in = 16'h8000;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bg_ack_out !== 1'b0 || mem_free_out !== 1'b1) acks++;
    end
    total++;
    if (acks !== 0) begin
      bad++; $display("[TB] FAIL prio_spr_wins got=%0d bad cycles want=0", acks);
    end
    spr_lock_in = 0;
    tick();                                        // SPR -> IDLE
    total++;
    if ({mem_free_out, bg_ack_out} !== 2'b10) begin
      bad++; $display("[TB] FAIL prio_idle_gap got=%b%b want=10", mem_free_out, bg_ack_out);
    end
    tick();                                        // IDLE -> BG
    total++;
    if ({mem_free_out, bg_ack_out} !== 2'b00) begin
      bad++; $display("[TB] FAIL prio_bg_owner got=%b%b want=00", mem_free_out, bg_ack_out);
    end
    tick();                                        // BG issues
    total++;
    if ({bg_ack_out, mem_addr_out} !== {1'b1, 16'h8000}) begin
      bad++; $display("[TB] FAIL prio_bg_ack got=%b %h want=1 8000", bg_ack_out, mem_addr_out);
    end
    bg_req_in = 0; bg_lock_in = 0;
    repeat (5) tick();
  endtask

  task automatic test_yield();
    do_reset();
    bg_lock_in = 1; bg_req_in = 1; bg_addr_in = 16'h9000;
    mem_data_in = 8'h5A; mem_data_valid_in = 1;
    tick(); tick();                                // cycle 2: issued
    bg_req_in = 0; spr_lock_in = 1;
    tick();                                        // cycle 3
    total++;
    if ({bg_yield_out, mem_free_out} !== 2'b10) begin
      bad++; $display("[TB] FAIL yield_flags got=%b%b want=10", bg_yield_out, mem_free_out);
    end
    tick(); tick();                                // cycle 5: BG response
    total++;
    if ({bg_rvalid_out, bg_rdata_out, spr_rvalid_out} !== {1'b1, 8'h5A, 1'b0}) begin
      bad++;
      $display("[TB] FAIL yield_bg_resp got=%b %h %b want=1 5a 0", bg_rvalid_out, bg_rdata_out, spr_rvalid_out);
    end
    bg_lock_in = 0;
    tick();                                        // cycle 6: IDLE
    spr_req_in = 1; spr_addr_in = 16'hFE00;
    total++;
    if ({bg_yield_out, mem_free_out} !== 2'b01) begin
      bad++; $display("[TB] FAIL yield_idle got=%b%b want=01", bg_yield_out, mem_free_out);
    end
    tick();                                        // cycle 7: SPR owner, not yet issued
    total++;
    if ({spr_ack_out, mem_free_out} !== 2'b01) begin
      bad++; $display("[TB] FAIL yield_spr_owner got=%b%b want=01", spr_ack_out, mem_free_out);
    end
    tick();                                        // cycle 8: sprite issue
    total++;
    if ({spr_ack_out, mem_addr_out, bg_ack_out} !== {1'b1, 16'hFE00, 1'b0}) begin
      bad++; $display("[TB] FAIL yield_spr_ack got=%b %h %b want=1 fe00 0", spr_ack_out, mem_addr_out, bg_ack_out);
    end
    spr_req_in = 0; spr_lock_in = 0;
    repeat (5) tick();
  endtask

  task automatic test_invalid_data();
    do_reset();
    spr_lock_in = 1; spr_req_in = 1; spr_addr_in = 16'hFE06;
    mem_data_in = 8'h77; mem_data_valid_in = 0;
    tick(); tick();                                // cycle 2: issue
    total++;
    if ({spr_ack_out, mem_addr_out} !== {1'b1, 16'hFE06}) begin
      bad++; $display("[TB] FAIL inv_ack got=%b %h want=1 fe06", spr_ack_out, mem_addr_out);
    end
    spr_req_in = 0;
    tick(); tick(); tick();                        // cycle 5: response
    total++;
    if ({spr_rvalid_out, spr_rdata_out, bg_rvalid_out} !== {1'b1, 8'hFF, 1'b0}) begin
      bad++;
      $display("[TB] FAIL inv_resp got=%b %h %b want=1 ff 0", spr_rvalid_out, spr_rdata_out, bg_rvalid_out);
    end
    spr_lock_in = 0;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    int acks;
    do_reset();
    bg_lock_in = 1; bg_req_in = 1; bg_addr_in = 16'h8010;
    mem_data_in = 8'hA1; mem_data_valid_in = 1;
    tick(); tick();                                // cycle 2: first issue
    total++;
    if ({bg_ack_out, mem_addr_out} !== {1'b1, 16'h8010}) begin
      bad++; $display("[TB] FAIL b2b_ack1 got=%b %h want=1 8010", bg_ack_out, mem_addr_out);
    end
    bg_addr_in = 16'h8011;
    acks = 0;
    tick(); if (bg_ack_out !== 1'b0) acks++;       // cycle 3
    tick(); if (bg_ack_out !== 1'b0) acks++;       // cycle 4
    total++;
    if (acks !== 0) begin
      bad++; $display("[TB] FAIL b2b_held_reissue got=%0d acks want=0", acks);
    end
    tick();                                        // cycle 5: first response
    mem_data_in = 8'hB2;
    total++;
    if ({bg_rvalid_out, bg_rdata_out, bg_ack_out} !== {1'b1, 8'hA1, 1'b0}) begin
      bad++; $display("[TB] FAIL b2b_resp1 got=%b %h %b want=1 a1 0", bg_rvalid_out, bg_rdata_out, bg_ack_out);
    end
    tick();                                        // cycle 6: second issue
    total++;
    if ({bg_ack_out, mem_req_out, mem_addr_out} !== {1'b1, 1'b1, 16'h8011}) begin
      bad++; $display("[TB] FAIL b2b_ack2 got=%b%b %h want=11 8011", bg_ack_out, mem_req_out, mem_addr_out);
    end
    bg_req_in = 0;
    tick(); tick(); tick();                        // cycle 9: second response
    total++;
    if ({bg_rvalid_out, bg_rdata_out} !== {1'b1, 8'hB2}) begin
      bad++; $display("[TB] FAIL b2b_resp2 got=%b %h want=1 b2", bg_rvalid_out, bg_rdata_out);
    end
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bg_ack_out !== 1'b0) acks++;
    end
    total++;
    if (acks !== 0) begin
      bad++; $display("[TB] FAIL b2b_extra_ack got=%0d want=0", acks);
    end
    bg_lock_in = 0;
    repeat (3) tick();
  endtask

  task automatic test_reset_inflight();
    int hits;
    do_reset();
    bg_lock_in = 1; bg_req_in = 1; bg_addr_in = 16'h1234;
    mem_data_in = 8'hC3; mem_data_valid_in = 1;
    tick(); tick();                                // cycle 2: issue
    bg_req_in = 0; bg_lock_in = 0; rst_in = 1;
    tick();                                        // cycle 3: reset taken
    rst_in = 0;
    total++;
    if ({mem_free_out, mem_req_out, bg_ack_out, bg_rvalid_out, bg_yield_out} !== 5'b10000) begin
      bad++;
      $display("[TB] FAIL rst_flight_state got=%b want=10000",
               {mem_free_out, mem_req_out, bg_ack_out, bg_rvalid_out, bg_yield_out});
    end
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bg_rvalid_out !== 1'b0 || spr_rvalid_out !== 1'b0 || bg_rdata_out !== 8'h00) hits++;
    end
    total++;
    if (hits !== 0) begin
      bad++; $display("[TB] FAIL rst_flight_drop got=%0d late responses want=0", hits);
    end
  endtask

  initial begin
    test_reset();
    test_bg_read();
    test_priority();
    test_yield();
    test_invalid_data();
    test_back_to_back();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
